serialize_words_to_bit_stream: RTL and testbench
================================================

// Module: serialize_words_to_bit_stream
//
// PURPOSE
// - Upstream feeder for the FSM sequence detectors: accepts WIDTH-bit words over a valid/ready handshake.
// - Emits them one bit per clock on a registered serial output `a`, ready to drive a detector's `a` input directly.
// - Back-to-back words stream with no idle gap; when no word is pending the line holds IDLE_BIT.
// - Sits between a word source (test pattern ROM, CPU reg, UART rx) and the detector.
//
// PARAMETERS
// - WIDTH     8   bits per word (>= 2)
// - IDLE_BIT  0   value driven on `a` while no word is being shifted
//
// PORTS
// - clk        in   1      single clock, all logic on posedge
// - rst        in   1      reset: one clock; reset is asynchronous and active-low (0 = reset)
// - up_valid   in   1      upstream word available
// - up_data    in   WIDTH  upstream word, sampled on handshake
// - up_ready   out  1      block can accept a word this cycle
// - a          out  1      serial bit stream to the detector (registered)
// - a_valid    out  1      1 = `a` carries a data bit; 0 = idle fill
// - word_done  out  1      one-cycle pulse while `a` carries the last bit of a word
//
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=IDLE, shift reg=0, bit_cnt=0.
//   - Outputs: a=IDLE_BIT, a_valid=0, word_done=0, up_ready=1.
// - FSM states:
//   - IDLE: no word in flight.
//   - SHIFT: bit_cnt counts 0..WIDTH-1.
// - Handshake:
//   - Transfer occurs at posedge when up_valid && up_ready.
//   - up_data must be held stable while up_valid=1 && up_ready=0.
// - up_ready (combinational): 1 in IDLE, or in SHIFT when bit_cnt==WIDTH-1. This gives zero-bubble chaining.
// - Latency: word accepted at edge N -> its first bit is on `a` (a_valid=1) during cycle N+1.
//   - Bit k appears in cycle N+1+k; the last bit appears in cycle N+WIDTH.
// - Bit order: MSB first (up_data[WIDTH-1] first) unless SERIALIZE_LSB_FIRST_EN is defined.
// - Transitions:
//   - IDLE + transfer -> SHIFT, bit_cnt=0.
//   - SHIFT, bit_cnt<WIDTH-1 -> SHIFT, bit_cnt+1.
//   - SHIFT, bit_cnt==WIDTH-1 + transfer -> SHIFT, bit_cnt=0, new word loaded (no idle cycle).
//   - SHIFT, bit_cnt==WIDTH-1, no transfer -> IDLE; next cycle a=IDLE_BIT, a_valid=0.
// - word_done = (state==SHIFT && bit_cnt==WIDTH-1), aligned with the last bit on `a`.
// - bit_cnt width is $clog2(WIDTH); it never exceeds WIDTH-1. There is no wrap beyond WIDTH-1.
// - up_valid deasserted mid-word: no effect; the current word completes.
// - up_valid toggling while up_ready=0: ignored. No partial loads.
// - Reset asserted mid-word: the word is discarded immediately (async).
//   - Outputs go to reset values within the same cycle; after release the block restarts from IDLE.
//   - No stale bits are emitted.
// - No X propagation: `a` is IDLE_BIT whenever a_valid=0.
//
// CONFIGURATION
// - Macro SERIALIZE_LSB_FIRST_EN:
//   - Defined: up_data[0] is emitted first and the shift register shifts right.
//   - Undefined (default): up_data[WIDTH-1] is emitted first and the shift register shifts left.
// - Handshake, latency and word_done timing are identical in both builds.
//
// TESTING (WIDTH=8, IDLE_BIT=0, MSB-first unless noted)
// - Single word: reset, then 8'b1010_1100 with up_valid for one cycle.
//   -> a = 1,0,1,0,1,1,0,0 in cycles 1..8, a_valid=1 for exactly 8 cycles.
//   -> word_done pulses in cycle 8, then a=0, a_valid=0.
// - Back-to-back: 8'hCC then 8'h33 with up_valid held high.
//   -> 16 contiguous valid bits 1100_1100_0011_0011.
//   -> up_ready=1 only in cycle 8 while shifting; word_done in cycles 8 and 16.
// - Chained into detect_6_bit_sequence_using_fsm: words 8'b0011_0011, 8'b0000_0000.
//   -> detector `detected` asserts exactly once, one cycle after the bit stream completes "110011".
// - Backpressure: up_valid=1 with 8'hFF presented during bits 2..6 of a prior word.
//   -> not accepted until up_ready; 8'hFF emitted intact afterwards.
// - Reset mid-word: rst=0 after bit 3 of 8'hF0.
//   -> a=0, a_valid=0, word_done=0 immediately (before next posedge).
//   -> after release, idle until a new word; remaining bits never appear.
// - SERIALIZE_LSB_FIRST_EN defined: 8'b1010_1100 -> a = 0,0,1,1,0,1,0,1, same timing as single-word test.

Source files
------------

// File: rtl/serialize_words_to_bit_stream.sv
// Word-to-bit serializer: WIDTH-bit words in over valid/ready, one bit per clock out on `a`.
// Define SERIALIZE_LSB_FIRST_EN to emit up_data[0] first (default is MSB first).
module serialize_words_to_bit_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             a,
    output logic             a_valid,
    output logic             word_done
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              a_q, a_d;
    logic              a_valid_q, a_valid_d;
    logic              last_bit;
    logic              xfer;

    always_comb begin
        last_bit  = (state_q == StShift) && (cnt_q == LastCnt);
        up_ready  = (state_q == StIdle) || last_bit;
        xfer      = up_valid && up_ready;
        word_done = last_bit;

        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StShift;
                    shift_d = up_data;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (!last_bit) begin
                    cnt_d = cnt_q + CntW'(1);
`ifdef SERIALIZE_LSB_FIRST_EN
                    shift_d = {1'b0, shift_q[WIDTH-1:1]};
`else
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
`endif
                end else if (xfer) begin
                    // Zero-bubble chaining: next word loads straight behind the last bit.
                    shift_d = up_data;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Output bit is taken from next-state so `a` itself is a flop.
        a_valid_d = (state_d == StShift);
`ifdef SERIALIZE_LSB_FIRST_EN
        a_d = a_valid_d ? shift_d[0] : IDLE_BIT;
`else
        a_d = a_valid_d ? shift_d[WIDTH-1] : IDLE_BIT;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            cnt_q     <= '0;
            a_q       <= IDLE_BIT;
            a_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;

endmodule

// File: tb/tb_serialize_words_to_bit_stream.sv
// Directed bench for serialize_words_to_bit_stream (WIDTH=8, IDLE_BIT=0).
// Expected bit order follows SERIALIZE_LSB_FIRST_EN when that macro is defined for the build.
module tb_serialize_words_to_bit_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_valid;
    logic [7:0] up_data;
    logic       up_ready;
    logic       a;
    logic       a_valid;
    logic       word_done;

    int n_tests = 0;
    int n_fail  = 0;

    serialize_words_to_bit_stream #(
        .WIDTH    (8),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .up_data   (up_data),
        .up_ready  (up_ready),
        .a         (a),
        .a_valid   (a_valid),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ea, input logic ev, input logic ed,
                           input logic er);
        chk({tag, ".a"}, a, ea);
        chk({tag, ".a_valid"}, a_valid, ev);
        chk({tag, ".word_done"}, word_done, ed);
        chk({tag, ".up_ready"}, up_ready, er);
    endtask

    // Bit k of word d in emission order.
    function automatic logic ebit(input logic [7:0] d, input int k);
`ifdef SERIALIZE_LSB_FIRST_EN
        return d[k];
`else
        return d[7-k];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] word;

        rst      = 1'b0;
        up_valid = 1'b0;
        up_data  = '0;
        #2;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b1;

        // Single word 8'b1010_1100 offered for one cycle.
        up_valid = 1'b1;
        up_data  = 8'hAC;
        chk_out("sw_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        up_valid = 1'b0;
        up_data  = '0;
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("sw_b%0d", k), ebit(8'hAC, k), 1'b1, k == 7, k == 7);
            tick();
        end
        chk_out("sw_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back 8'hCC then 8'h33, valid held high across the boundary.
        up_valid = 1'b1;
        up_data  = 8'hCC;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 7) up_data = 8'h33;
            if (k == 8) up_valid = 1'b0;
            word = (k < 8) ? 8'hCC : 8'h33;
            chk_out($sformatf("b2b_b%0d", k), ebit(word, k % 8), 1'b1, (k % 8) == 7,
                    (k % 8) == 7);
            tick();
        end
        chk_out("b2b_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: 8'hFF offered mid-word, must wait for up_ready.
        up_valid = 1'b1;
        up_data  = 8'h0F;
        tick();
        up_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                up_valid = 1'b1;
                up_data  = 8'hFF;
            end
            chk_out($sformatf("bp_w0_b%0d", k), ebit(8'h0F, k), 1'b1, k == 7, k == 7);
            tick();
        end
        up_valid = 1'b0;
        up_data  = '0;
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("bp_ff_b%0d", k), 1'b1, 1'b1, k == 7, k == 7);
            tick();
        end
        chk_out("bp_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word after three bits of 8'hF0.
        up_valid = 1'b1;
        up_data  = 8'hF0;
        tick();
        up_valid = 1'b0;
        up_data  = '0;
        for (int k = 0; k < 3; k++) begin
            chk_out($sformatf("rst_pre_b%0d", k), ebit(8'hF0, k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_out("rst_pre_b3", ebit(8'hF0, 3), 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk_out($sformatf("rst_idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end

        // Restart after reset with 8'h81.
        up_valid = 1'b1;
        up_data  = 8'h81;
        tick();
        up_valid = 1'b0;
        up_data  = '0;
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("post_b%0d", k), ebit(8'h81, k), 1'b1, k == 7, k == 7);
            tick();
        end
        chk_out("post_after", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
